// File: rtl/sb_tx_serializer.sv
// Sideband transmit serializer: SBINIT clock pattern generator and 64-bit packet
// shifter with a trailing idle gap, a one-entry pending buffer and status pulses.
module sb_tx_serializer #(
   parameter int         SB_MSG_WIDTH = 4,
   parameter int         PKT_WIDTH    = 64,
   parameter int         PATTERN_UI   = 64,
   parameter int         GAP_UI       = 32,
   parameter logic [4:0] OPCODE       = 5'b10010
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start_pattern_req,
   input  logic                    i_tx_msg_valid,
   input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
   output logic                    o_sb_data,
   output logic                    o_sb_clk_en,
   output logic                    o_SB_Busy,
   output logic                    o_falling_edge_busy,
   output logic                    o_start_pattern_done,
   output logic                    o_overflow
);

   localparam int CNT_MAX_A = (PKT_WIDTH > PATTERN_UI) ? PKT_WIDTH : PATTERN_UI;
   localparam int CNT_MAX   = (CNT_MAX_A > GAP_UI) ? CNT_MAX_A : GAP_UI;
   localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_WIDTH - 1);
   localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PATTERN_UI - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_UI - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PATTERN = 2'd1;
   localparam logic [1:0] MSG     = 2'd2;
   localparam logic [1:0] GAP     = 2'd3;

   // Packet layout: opcode in [4:0], code above it, even parity over [61:0] in bit 62.
   function automatic logic [PKT_WIDTH-1:0] build_pkt(input logic [SB_MSG_WIDTH-1:0] code);
      logic [PKT_WIDTH-1:0] p;
      p                      = '0;
      p[4:0]                 = OPCODE;
      p[SB_MSG_WIDTH+4:5]    = code;
      p[PKT_WIDTH-2]         = ^p[PKT_WIDTH-3:0];
      return p;
   endfunction

   logic [1:0]              state;
   logic [CNT_W-1:0]        cnt;
   logic                    is_pattern;
   logic                    pend_full;
   logic [SB_MSG_WIDTH-1:0] pend_code;
   logic [PKT_WIDTH-1:0]    shift_p0;

   logic                    msg_in;
   logic                    in_idle;
   logic                    launch_pat;
   logic                    launch_pend;
   logic                    launch_new;
   logic                    store;
   logic                    store_ok;
   logic [SB_MSG_WIDTH-1:0] launch_code;
   logic [PKT_WIDTH-1:0]    launch_pkt;

   // Launch arbitration: pattern request beats the pending entry, which beats a fresh code.
   always_comb begin
      msg_in      = i_tx_msg_valid && (i_encoded_SB_msg != '0);
      in_idle     = (state == IDLE);
      launch_pat  = in_idle && i_start_pattern_req;
      launch_pend = in_idle && !i_start_pattern_req && pend_full;
      launch_new  = in_idle && !i_start_pattern_req && !pend_full && msg_in;
      store       = msg_in && !launch_new;
      store_ok    = store && (!pend_full || launch_pend);
      launch_code = pend_full ? pend_code : i_encoded_SB_msg;
      launch_pkt  = build_pkt(launch_code);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state                <= IDLE;
         cnt                  <= '0;
         is_pattern           <= 1'b0;
         pend_full            <= 1'b0;
         o_sb_data            <= 1'b0;
         o_sb_clk_en          <= 1'b0;
         o_SB_Busy            <= 1'b0;
         o_falling_edge_busy  <= 1'b0;
         o_start_pattern_done <= 1'b0;
         o_overflow           <= 1'b0;
      end else begin
         o_falling_edge_busy  <= 1'b0;
         o_start_pattern_done <= 1'b0;
         o_overflow           <= 1'b0;

         case (state)
            IDLE: begin
               if (launch_pat) begin
                  state       <= PATTERN;
                  cnt         <= PAT_LAST;
                  is_pattern  <= 1'b1;
                  o_sb_data   <= 1'b1;
                  o_sb_clk_en <= 1'b1;
                  o_SB_Busy   <= 1'b1;
               end else if (launch_pend || launch_new) begin
                  state       <= MSG;
                  cnt         <= PKT_LAST;
                  is_pattern  <= 1'b0;
                  o_sb_data   <= launch_pkt[0];
                  o_sb_clk_en <= 1'b1;
                  o_SB_Busy   <= 1'b1;
               end
            end
            PATTERN: begin
               if (cnt == '0) begin
                  state       <= GAP;
                  cnt         <= GAP_LAST;
                  o_sb_data   <= 1'b0;
                  o_sb_clk_en <= 1'b0;
               end else begin
                  cnt       <= cnt - 1'b1;
                  o_sb_data <= ~o_sb_data;
               end
            end
            MSG: begin
               if (cnt == '0) begin
                  state       <= GAP;
                  cnt         <= GAP_LAST;
                  o_sb_data   <= 1'b0;
                  o_sb_clk_en <= 1'b0;
               end else begin
                  cnt       <= cnt - 1'b1;
                  o_sb_data <= shift_p0[0];
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state                <= IDLE;
                  o_SB_Busy            <= 1'b0;
                  o_falling_edge_busy  <= 1'b1;
                  o_start_pattern_done <= is_pattern;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // A consumed entry frees the slot in the same cycle a new code lands in it.
         if (store) begin
            if (store_ok) pend_full  <= 1'b1;
            else          o_overflow <= 1'b1;
         end else if (launch_pend) begin
            pend_full <= 1'b0;
         end
      end
   end

   // Datapath registers carry no reset; pend_full and state qualify them.
   always_ff @(posedge i_clk) begin
      if (store_ok) pend_code <= i_encoded_SB_msg;
      if (launch_pend || launch_new) shift_p0 <= launch_pkt >> 1;
      else if (state == MSG)         shift_p0 <= shift_p0 >> 1;
   end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed bench for sb_tx_serializer: captures outputs per cycle after each launch
// and compares windows of the capture against hand-computed constants.
module tb_sb_tx_serializer;

   logic       clk;
   logic       rst;
   logic       req;
   logic       vld;
   logic [3:0] code;
   logic       sb_data, sb_clk_en, busy, feb, pdone, ovf;

   int n_cmp = 0;
   int n_err = 0;

   logic [511:0] cd, ce, cb, cf, cp, co;

   // Hand-built packets: opcode 10010, code in [8:5], even parity in bit 62.
   localparam logic [63:0] PKT_C3 = 64'h0000_0000_0000_0072;
   localparam logic [63:0] PKT_C5 = 64'h0000_0000_0000_00B2;
   localparam logic [63:0] PKT_C1 = 64'h4000_0000_0000_0032;
   localparam logic [63:0] PAT    = 64'h5555_5555_5555_5555;

   sb_tx_serializer dut (
      .i_clk                (clk),
      .i_rst                (rst),
      .i_start_pattern_req  (req),
      .i_tx_msg_valid       (vld),
      .i_encoded_SB_msg     (code),
      .o_sb_data            (sb_data),
      .o_sb_clk_en          (sb_clk_en),
      .o_SB_Busy            (busy),
      .o_falling_edge_busy  (feb),
      .o_start_pattern_done (pdone),
      .o_overflow           (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      cd = '0; ce = '0; cb = '0; cf = '0; cp = '0; co = '0;
   endtask

   task automatic cap(input int from, input int to);
      for (int k = from; k <= to; k++) begin
         @(negedge clk);
         cd[k] = sb_data; ce[k] = sb_clk_en; cb[k] = busy;
         cf[k] = feb;     cp[k] = pdone;     co[k] = ovf;
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("wait_idle", 512'(busy), 512'(0));
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; vld = 1'b0; code = 4'd0;
      @(negedge clk); @(negedge clk);
      check("rst_outputs", 512'({sb_data, sb_clk_en, busy, feb, pdone, ovf}), 512'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single message, code 3
      clr(); vld = 1'b1; code = 4'd3;
      cap(1, 1); vld = 1'b0; code = 4'd0;
      cap(2, 98);
      check("m3_first5",   512'(cd[5:1]),   512'(5'b10010));
      check("m3_bits6_9",  512'(cd[9:6]),   512'(4'b0011));
      check("m3_parity",   512'(cd[63]),    512'(0));
      check("m3_pkt",      512'(cd[64:1]),  512'(PKT_C3));
      check("m3_clken",    512'(ce[64:1]),  512'({64{1'b1}}));
      check("m3_gap_data", 512'(cd[96:65]), 512'(0));
      check("m3_gap_en",   512'(ce[96:65]), 512'(0));
      check("m3_busy",     512'(cb[97:1]),  512'({1'b0, {96{1'b1}}}));
      check("m3_feb",      512'(cf[98:1]),  512'({2'b01, 96'd0}));
      check("m3_ovf",      512'(co[98:1]),  512'(0));
      check("m3_pdone",    512'(cp[98:1]),  512'(0));

      // One pattern iteration
      clr(); req = 1'b1;
      cap(1, 1); req = 1'b0;
      cap(2, 98);
      check("pat_bits",    512'(cd[64:1]),  512'(PAT));
      check("pat_clken",   512'(ce[64:1]),  512'({64{1'b1}}));
      check("pat_gap",     512'({cd[96:65], ce[96:65]}), 512'(0));
      check("pat_done",    512'(cp[98:1]),  512'({2'b01, 96'd0}));
      check("pat_feb",     512'(cf[98:1]),  512'({2'b01, 96'd0}));
      check("pat_busy",    512'(cb[98:96]), 512'(3'b001));

      // Pattern and code 5 in the same IDLE cycle
      clr(); req = 1'b1; vld = 1'b1; code = 4'd5;
      cap(1, 1); req = 1'b0; vld = 1'b0; code = 4'd0;
      cap(2, 170);
      check("pm_pat",      512'(cd[64:1]),   512'(PAT));
      check("pm_done",     512'(cp[97]),     512'(1));
      check("pm_busy_gap", 512'(cb[98:96]),  512'(3'b101));
      check("pm_pkt",      512'(cd[161:98]), 512'(PKT_C5));
      check("pm_clken",    512'(ce[161:98]), 512'({64{1'b1}}));
      check("pm_ovf",      512'(co[170:1]),  512'(0));
      wait_idle();

      // Three codes during one packet: 1 held, 2 and 3 dropped
      clr(); vld = 1'b1; code = 4'd3;
      cap(1, 1); code = 4'd1;
      cap(2, 2); code = 4'd2;
      cap(3, 3); code = 4'd3;
      cap(4, 4); vld = 1'b0; code = 4'd0;
      cap(5, 200);
      check("ov_pulses",   512'(co[6:1]),    512'(6'b001100));
      check("ov_quiet",    512'(co[200:7]),  512'(0));
      check("ov_pkt0",     512'(cd[64:1]),   512'(PKT_C3));
      check("ov_feb",      512'(cf[97]),     512'(1));
      check("ov_pkt1",     512'(cd[161:98]), 512'(PKT_C1));
      check("ov_busy2",    512'(cb[194:193]),512'(2'b01));
      wait_idle();

      // Code 0 is ignored
      clr(); vld = 1'b1; code = 4'd0;
      cap(1, 1); vld = 1'b0;
      cap(2, 10);
      check("z_busy",      512'(cb[10:1]), 512'(0));
      check("z_data",      512'({cd[10:1], ce[10:1]}), 512'(0));
      check("z_ovf_feb",   512'({co[10:1], cf[10:1]}), 512'(0));

      // Reset mid-packet, then a normal packet
      clr(); vld = 1'b1; code = 4'd3;
      cap(1, 1); vld = 1'b0; code = 4'd0;
      cap(2, 30);
      check("r_busy_pre",  512'(cb[30]), 512'(1));
      rst = 1'b1;
      #1;
      check("r_async",     512'({sb_data, sb_clk_en, busy, feb, pdone, ovf}), 512'(0));
      @(negedge clk); @(negedge clk);
      check("r_held",      512'({sb_data, sb_clk_en, busy, feb, pdone, ovf}), 512'(0));
      rst = 1'b0;
      @(negedge clk);
      check("r_idle",      512'(busy), 512'(0));
      clr(); vld = 1'b1; code = 4'd1;
      cap(1, 1); vld = 1'b0; code = 4'd0;
      cap(2, 98);
      check("r_pkt",       512'(cd[64:1]), 512'(PKT_C1));
      check("r_busy",      512'(cb[97:1]), 512'({1'b0, {96{1'b1}}}));
      check("r_feb",       512'(cf[98:1]), 512'({2'b01, 96'd0}));
      check("r_ovf",       512'(co[98:1]), 512'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sb_tx_serializer.md
# sb_tx_serializer

Sideband transmit front-end that sits directly downstream of the SBINIT wrapper and the other LTSM substates. It consumes the encoded message code and valid strobe, generates the 64UI SBINIT clock pattern on request, and serializes a 64-bit sideband packet one bit per clock with the mandatory 32UI idle gap. It feeds busy, falling-edge-busy and pattern-done status back upstream.

## Interface
- SB_MSG_WIDTH, 4: width of the encoded message code.
- PKT_WIDTH, 64: serialized packet length in bits.
- PATTERN_UI, 64: length of the alternating SBINIT pattern in cycles.
- GAP_UI, 32: idle-low cycles after every packet or pattern.
- OPCODE, 5'b10010: constant placed in packet bits [4:0].

Ports:
- i_clk  in  1  sideband serializer clock, one UI per cycle.
- i_rst  in  1  asynchronous, active-high reset.
- i_start_pattern_req  in  1  level request for one pattern iteration.
- i_tx_msg_valid  in  1  one-cycle strobe; i_encoded_SB_msg is valid this cycle.
- i_encoded_SB_msg  in  SB_MSG_WIDTH  message code; 0 is reserved (no message).
- o_sb_data  out  1  serial data, LSB first.
- o_sb_clk_en  out  1  high in cycles carrying pattern or packet bits.
- o_SB_Busy  out  1  high while a pattern, packet or gap is in progress.
- o_falling_edge_busy  out  1  one-cycle pulse on the first cycle o_SB_Busy is low after being high.
- o_start_pattern_done  out  1  one-cycle pulse when a pattern iteration (including its gap) completes.
- o_overflow  out  1  one-cycle pulse when a message is dropped.

## Operation
- FSM states: IDLE, PATTERN, MSG, GAP. A single down-counter is sized to cover max(PKT_WIDTH, PATTERN_UI, GAP_UI).
- Launch arbitration in IDLE, in priority order:
  - i_start_pattern_req high -> PATTERN.
  - Pending buffer full -> MSG with the pending code.
  - i_tx_msg_valid with nonzero code -> MSG with the input code.
- PATTERN: o_sb_data alternates 1,0,1,0,… for PATTERN_UI cycles, starting with 1. Then GAP.
- MSG: shift out a packet built at launch:
  - bits [4:0] = OPCODE;
  - bits [SB_MSG_WIDTH+4:5] = code;
  - bit 62 = XOR of bits [61:0] (even parity);
  - all other bits 0.
  - After PKT_WIDTH cycles, go to GAP.
- GAP: o_sb_data = 0 and o_sb_clk_en = 0 for GAP_UI cycles, then IDLE.
- Pending buffer, one entry:
  - A valid nonzero code is stored if it is not launched directly. This covers valid arriving in any non-IDLE state, and valid losing arbitration in IDLE.
  - Consuming the pending entry and storing a new code in the same cycle is allowed.
  - If the buffer is full and not being consumed, the new code is dropped and o_overflow pulses next cycle.
- Valid with code 0 is ignored entirely: no store, no overflow.
- i_start_pattern_req held high re-launches a new iteration at the first IDLE cycle.
- Reset, including mid-packet: state IDLE, counter 0, pending cleared, all outputs 0 on the next edge of i_rst.

## Timing
- Reset value of every output: 0.
- All outputs are registered.
- Message accepted in IDLE at cycle T:
  - o_SB_Busy = 1 and o_sb_clk_en = 1 from T+1.
  - o_sb_data carries bit 0 at T+1 and bit 63 at T+64.
  - GAP runs T+65..T+96.
  - State is IDLE at T+97, with o_SB_Busy = 0 and o_falling_edge_busy = 1 for T+97 only.
- Pattern accepted at T: pattern bits T+1..T+64, gap T+65..T+96. At T+97, o_start_pattern_done and o_falling_edge_busy both pulse, and o_SB_Busy = 0.
- Back-to-back launches: the earliest next launch decision is at T+97 (in IDLE), with the next first bit at T+98. o_SB_Busy is low for exactly one cycle in between.
- Worst-case latency for a buffered message: completion of the current operation + 1 cycle.

## Test plan
- Reset, then valid with code 4'b0011 at T -> o_sb_data over T+1..T+5 = 0,1,0,0,1; over T+6..T+9 = 1,1,0,0; bit 62 (at T+63) = 0; busy falls and falling-edge pulses at T+97.
- Pattern request held 1 cycle at T -> 64 alternating bits 1,0,… from T+1, 32 zeros, o_start_pattern_done pulse at T+97 only.
- Pattern request and valid code 4'b0101 in the same IDLE cycle -> pattern first, then packet with code 0101 launched from the IDLE cycle at T+97 (first bit T+98), no overflow.
- Three valid codes (1, 2, 3) during one packet -> code 1 pending, codes 2 and 3 each produce an o_overflow pulse; code 1 is sent next.
- Valid with code 0 in IDLE -> o_SB_Busy stays 0, no output activity, no overflow.
- i_rst asserted at T+30 mid-packet -> all outputs 0 asynchronously; after release, a new valid code 4'b0001 is transmitted normally.
